xbar_conflict_sched: RTL and testbench

Conflict-resolving ingress scheduler that sits directly upstream of the crossbar's switch-setting stage. Each cycle it collects per-requester (destination, data) requests, grants a destination-conflict-free subset using per-destination round-robin arbitration, and registers the resulting permutation and aligned data for the downstream stage. Losing requesters are back-pressured and retried. Downstream blocks therefore never see two active inputs aimed at the same output.

---
 rtl/xbar_sched_pkg.sv | 10 +
 rtl/xbar_conflict_sched_rr_arb.sv | 48 ++++
 rtl/xbar_conflict_sched.sv | 126 ++++++++++++
 tb/tb_xbar_conflict_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_sched_pkg.sv
// Shared sizing defaults and types for the crossbar ingress scheduler.
package xbar_sched_pkg;

    localparam int XBOT_N    = 32;
    localparam int LOG_REQ_N = 5;

    typedef logic [LOG_REQ_N-1:0] dest_t;
    typedef logic [XBOT_N-1:0]    req_vec_t;

endpackage

// File: rtl/xbar_conflict_sched_rr_arb.sv
// Rotating-priority N-to-1 arbiter; any request flagged in the override mask
// beats the rotation, lowest index first.
module rr_arb
    import xbar_sched_pkg::*;
#(
    parameter int XBOT_N    = xbar_sched_pkg::XBOT_N,
    parameter int LOG_REQ_N = xbar_sched_pkg::LOG_REQ_N
) (
    input  logic [XBOT_N-1:0]    req,
    input  logic [LOG_REQ_N-1:0] ptr,
    input  logic [XBOT_N-1:0]    ovr,
    output logic [XBOT_N-1:0]    gnt,
    output logic [LOG_REQ_N-1:0] idx
);

    logic [XBOT_N-1:0] hot;

    assign hot = req & ovr;

    always_comb begin
        logic                 found;
        logic [LOG_REQ_N-1:0] cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (|hot) begin
            for (int i = 0; i < XBOT_N; i++) begin
                if (!found && hot[i]) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = LOG_REQ_N'(i);
                end
            end
        end else begin
            // Index arithmetic wraps naturally because XBOT_N is a power of two.
            for (int k = 0; k < XBOT_N; k++) begin
                cand = ptr + LOG_REQ_N'(k);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                end
            end
        end
    end

endmodule

// File: rtl/xbar_conflict_sched.sv
// Grants a destination-conflict-free subset of requests and registers the permutation.
// Optional starvation override is enabled by defining XBAR_SCHED_STARVE_EN.
module xbar_conflict_sched
    import xbar_sched_pkg::*;
#(
    parameter int XBOT_N    = xbar_sched_pkg::XBOT_N,
    parameter int LOG_REQ_N = xbar_sched_pkg::LOG_REQ_N,
    parameter int DATA_W    = 128,
    parameter int STARVE_TH = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [XBOT_N-1:0]                    req_valid_i,
    input  logic [XBOT_N-1:0][LOG_REQ_N-1:0]     req_dest_i,
    input  logic [XBOT_N-1:0][DATA_W-1:0]        req_data_i,
    output logic [XBOT_N-1:0]                    req_ready_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [XBOT_N-1:0]                    out_active_o,
    output logic [XBOT_N-1:0][LOG_REQ_N-1:0]     out_dest_o,
    output logic [XBOT_N-1:0][DATA_W-1:0]        out_data_o
);

    logic                 free;
    logic [XBOT_N-1:0]    ovr;
    logic [XBOT_N-1:0]    grant;
    logic [XBOT_N-1:0]    creq   [XBOT_N];
    logic [XBOT_N-1:0]    gnt_d  [XBOT_N];
    logic [LOG_REQ_N-1:0] idx_d  [XBOT_N];
    logic [LOG_REQ_N-1:0] rr_ptr [XBOT_N];

    assign free = ~out_valid_o | out_ready_i;

    always_comb begin
        for (int d = 0; d < XBOT_N; d++) begin
            for (int i = 0; i < XBOT_N; i++) begin
                creq[d][i] = req_valid_i[i] && (req_dest_i[i] == LOG_REQ_N'(d));
            end
        end
    end

    for (genvar d = 0; d < XBOT_N; d++) begin : g_arb
        rr_arb #(
            .XBOT_N    (XBOT_N),
            .LOG_REQ_N (LOG_REQ_N)
        ) u_arb (
            .req (creq[d]),
            .ptr (rr_ptr[d]),
            .ovr (ovr),
            .gnt (gnt_d[d]),
            .idx (idx_d[d])
        );
    end

    always_comb begin
        grant = '0;
        for (int d = 0; d < XBOT_N; d++) begin
            grant = grant | gnt_d[d];
        end
    end

    // Grants are only real when the output register can take them.
    assign req_ready_o = (free && !rst) ? grant : '0;

`ifdef XBAR_SCHED_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_TH + 1);

    logic [WAIT_W-1:0] wait_cnt [XBOT_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < XBOT_N; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < XBOT_N; i++) begin
                if (req_ready_o[i]) begin
                    wait_cnt[i] <= '0;
                end else if (req_valid_i[i] && wait_cnt[i] != WAIT_W'(STARVE_TH)) begin
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < XBOT_N; i++) begin
            ovr[i] = (wait_cnt[i] == WAIT_W'(STARVE_TH));
        end
    end
`else
    localparam int unused_starve_th = STARVE_TH;

    assign ovr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < XBOT_N; d++) rr_ptr[d] <= '0;
        end else if (free) begin
            for (int d = 0; d < XBOT_N; d++) begin
                if (|gnt_d[d]) rr_ptr[d] <= idx_d[d] + LOG_REQ_N'(1);
            end
        end
    end

    // Output register: load, drain or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            out_active_o <= '0;
            out_dest_o   <= '0;
            out_data_o   <= '0;
        end else if (free) begin
            if (|grant) begin
                out_valid_o  <= 1'b1;
                out_active_o <= grant;
                for (int i = 0; i < XBOT_N; i++) begin
                    out_dest_o[i] <= grant[i] ? req_dest_i[i] : '0;
                    out_data_o[i] <= grant[i] ? req_data_i[i] : '0;
                end
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xbar_conflict_sched.sv
// Randomized and directed bench for xbar_conflict_sched against a per-destination scan model.
module tb_xbar_conflict_sched;
    import xbar_sched_pkg::*;

    localparam int N  = 32;
    localparam int LW = 5;
    localparam int DW = 128;
    localparam int TH = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    req_vec_t                req_valid;
    logic [N-1:0][LW-1:0]    req_dest;
    logic [N-1:0][DW-1:0]    req_data;
    req_vec_t                req_ready;
    logic                    out_valid;
    logic                    out_ready;
    req_vec_t                out_active;
    logic [N-1:0][LW-1:0]    out_dest;
    logic [N-1:0][DW-1:0]    out_data;

    always #5 clk = ~clk;

    xbar_conflict_sched #(
        .XBOT_N    (N),
        .LOG_REQ_N (LW),
        .DATA_W    (DW),
        .STARVE_TH (TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_dest_i   (req_dest),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_active_o (out_active),
        .out_dest_o   (out_dest),
        .out_data_o   (out_data)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state
    logic          pv   [N];
    logic [LW-1:0] pd   [N];
    logic [DW-1:0] pdat [N];
    logic          ordy;

    // Reference model state
    int            mptr  [N];
    int            mwait [N];
    logic          mv;
    logic [N-1:0]  ma;
    logic [LW-1:0] md    [N];
    logic [DW-1:0] mdat  [N];

    logic [N-1:0]  last_gnt;
    logic [N-1:0]  rdy_seen;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        int w;
        int i;
        g = '0;
        if (mv && !ordy) return '0;
        for (int d = 0; d < N; d++) begin
            w = -1;
`ifdef XBAR_SCHED_STARVE_EN
            for (int s = 0; s < N; s++) begin
                if (w < 0 && pv[s] && int'(pd[s]) == d && mwait[s] == TH) w = s;
            end
`endif
            for (int k = 0; k < N; k++) begin
                i = (mptr[d] + k) % N;
                if (w < 0 && pv[i] && int'(pd[i]) == d) w = i;
            end
            if (w >= 0) g[w] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mptr[i]  = 0;
            mwait[i] = 0;
            md[i]    = '0;
            mdat[i]  = '0;
        end
        mv = 1'b0;
        ma = '0;
    endtask

    task automatic model_update(input logic [N-1:0] g);
        logic free;
        free = !mv || ordy;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                mptr[int'(pd[i])] = (i + 1) % N;
                mwait[i] = 0;
            end else if (pv[i] && mwait[i] < TH) begin
                mwait[i] = mwait[i] + 1;
            end
        end
        if (free) begin
            if (|g) begin
                mv = 1'b1;
                ma = g;
                for (int i = 0; i < N; i++) begin
                    md[i]   = g[i] ? pd[i] : '0;
                    mdat[i] = g[i] ? pdat[i] : '0;
                end
            end else begin
                mv = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic r);
        rst       = r;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pv[i];
            req_dest[i]  = pd[i];
            req_data[i]  = pdat[i];
        end
        #1;
        rdy_seen = req_ready;
        if (r) begin
            last_gnt = '0;
            chk("ready_in_rst", 160'(rdy_seen), 160'(0));
        end else begin
            last_gnt = model_grant();
            chk("ready", 160'(rdy_seen), 160'(last_gnt));
        end
        @(posedge clk);
        if (r) model_reset();
        else   model_update(last_gnt);
        #1;
        chk("out_valid", 160'(out_valid), 160'(mv));
        chk("out_active", 160'(out_active), 160'(ma));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out_slot%0d", i), 160'({out_dest[i], out_data[i]}), 160'({md[i], mdat[i]}));
        end
    endtask

    task automatic set_req(input int i, input int d);
        pv[i]   = 1'b1;
        pd[i]   = LW'(d);
        pdat[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
    endtask

    task automatic retire();
        for (int i = 0; i < N; i++) if (last_gnt[i]) pv[i] = 1'b0;
    endtask

    initial begin
        int conf_order [4];
        logic rr;
        int span;

        ordy = 1'b1;
        for (int i = 0; i < N; i++) begin
            pd[i] = '0;
            pdat[i] = '0;
        end
        clear_all();
        model_reset();

        // Reset with every requester valid, then the identity permutation
        for (int i = 0; i < N; i++) set_req(i, i);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        chk("id_ready", 160'(rdy_seen), 160'(32'hFFFF_FFFF));
        chk("id_valid", 160'(out_valid), 160'(1));
        chk("id_active", 160'(out_active), 160'(32'hFFFF_FFFF));
        chk("id_dest31", 160'(out_dest[31]), 160'(31));
        retire();
        cycle(1'b0);
        chk("drain_valid", 160'(out_valid), 160'(0));

        // Three requesters contending for destination 5
        cycle(1'b1);
        conf_order = '{3, 7, 20, 3};
        set_req(3, 5);
        set_req(7, 5);
        set_req(20, 5);
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0);
            chk($sformatf("conflict_gnt%0d", n), 160'(rdy_seen), 160'(32'd1 << conf_order[n]));
        end
        clear_all();
        cycle(1'b0);

        // Mixed: two on destination 1, one on destination 4
        cycle(1'b1);
        set_req(0, 1);
        set_req(1, 1);
        set_req(2, 4);
        cycle(1'b0);
        chk("mixed_gnt0", 160'(rdy_seen), 160'(32'h5));
        retire();
        cycle(1'b0);
        chk("mixed_gnt1", 160'(rdy_seen), 160'(32'h2));
        retire();
        cycle(1'b0);

        // Back-pressure with pending requests, then release
        set_req(0, 2);
        cycle(1'b0);
        retire();
        ordy = 1'b0;
        set_req(1, 3);
        set_req(2, 3);
        set_req(3, 9);
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0);
            chk("bp_ready", 160'(rdy_seen), 160'(0));
            chk("bp_active", 160'(out_active), 160'(32'h1));
        end
        ordy = 1'b1;
        cycle(1'b0);
        chk("bp_release_gnt", 160'(rdy_seen), 160'(32'hA));
        chk("bp_release_valid", 160'(out_valid), 160'(1));
        chk("bp_release_active", 160'(out_active), 160'(32'hA));
        clear_all();
        cycle(1'b0);

`ifdef XBAR_SCHED_STARVE_EN
        // Requester 1 joins behind the pointer against six continuous rivals
        cycle(1'b1);
        for (int i = 2; i < 8; i++) set_req(i, 0);
        cycle(1'b0);
        set_req(1, 0);
        begin
            int waited;
            waited = 0;
            for (int n = 0; n < 8; n++) begin
                if (waited == 0) begin
                    cycle(1'b0);
                    if (rdy_seen[1]) waited = n + 1;
                end
            end
            chk("starve_latency", 160'(waited), 160'(4));
        end
        clear_all();
        cycle(1'b0);
`endif

        // Random traffic, narrow destination range first to force conflicts
        cycle(1'b1);
        for (int c = 0; c < 400; c++) begin
            rr   = ($urandom_range(0, 63) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            span = (c < 200) ? 4 : N;
            for (int i = 0; i < N; i++) begin
                if (!pv[i] || last_gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, int'($urandom_range(0, span - 1)));
                    else pv[i] = 1'b0;
                end
            end
            cycle(rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
